bp_maint_ctrl: RTL and testbench

Maintenance and update scheduler for the branch-predictor tables (PHT/BTB), which have a single write port. It owns that port and shares it between two sources: resolved-branch updates from EX, and a full-table clear sweep run after reset or on a flush request (e.g. fence.i). EX updates that arrive while the port is busy wait in a small FIFO. Fetch-side prediction is gated off until the tables are consistent.

---
 rtl/bp_maint_if.sv | 52 +++++
 rtl/bp_maint_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bp_maint_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_maint_if.sv
// ============================================================================
// Module   : bp_maint_if
// Purpose  : Update, flush and table-write signals of the branch-predictor
//            maintenance scheduler, with EX-side (master) and controller
//            (slave) views.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bp_maint_if #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 32
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic             upd_valid;
  logic             upd_ready;
  logic [WIDTH-1:0] upd_pc;
  logic             upd_taken;
  logic             upd_jump;
  logic             upd_call;
  logic             upd_ret;
  logic [WIDTH-1:0] upd_target;
  logic             flush_req;
  logic             flush_busy;
  logic             predict_en;
  logic             tbl_we;
  logic             tbl_clr;
  logic [IDX_W-1:0] tbl_idx;
  logic [WIDTH-1:0] tbl_pc;
  logic [WIDTH-1:0] tbl_target;
  logic             tbl_taken;
  logic             tbl_jump;
  logic             tbl_call;
  logic             tbl_ret;

  modport master (
    output upd_valid, upd_pc, upd_taken, upd_jump, upd_call, upd_ret,
           upd_target, flush_req,
    input  upd_ready, flush_busy, predict_en, tbl_we, tbl_clr, tbl_idx,
           tbl_pc, tbl_target, tbl_taken, tbl_jump, tbl_call, tbl_ret
  );

  modport slave (
    input  upd_valid, upd_pc, upd_taken, upd_jump, upd_call, upd_ret,
           upd_target, flush_req,
    output upd_ready, flush_busy, predict_en, tbl_we, tbl_clr, tbl_idx,
           tbl_pc, tbl_target, tbl_taken, tbl_jump, tbl_call, tbl_ret
  );
endinterface

`default_nettype wire

// File: rtl/bp_maint_ctrl.sv
// ============================================================================
// Module   : bp_maint_ctrl
// Purpose  : Owns the single PHT/BTB write port; interleaves a full-table
//            clear sweep (reset / flush) with queued EX branch updates.
//            Optional macro BP_UPD_BYPASS_EN: zero-latency write of an update
//            arriving in RUN while the queue is empty.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_maint_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 32,
  parameter int QDEPTH  = 4
) (
  input  logic      clk,
  input  logic      rst,
  bp_maint_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(QDEPTH);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target;
    logic             taken;
    logic             jump;
    logic             call;
    logic             ret;
  } entry_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_sweep_idx;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  entry_t           r_mem [QDEPTH];

  entry_t w_in;
  entry_t w_head;
  logic   w_accept;
  logic   w_bypass;
  logic   w_push;
  logic   w_pop;

  assign w_in = '{pc: bus.upd_pc, target: bus.upd_target, taken: bus.upd_taken,
                  jump: bus.upd_jump, call: bus.upd_call, ret: bus.upd_ret};
  assign w_head = r_mem[r_rd_ptr];

  // Ready comes from the registered count only: a same-cycle pop never frees a slot.
  assign bus.upd_ready = (r_count != C_FULL);
  assign w_accept      = bus.upd_valid && bus.upd_ready && !bus.flush_req;

`ifdef BP_UPD_BYPASS_EN
  assign w_bypass = w_accept && (r_state == ST_RUN) && (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && !w_bypass;
  assign w_pop  = (r_state == ST_RUN) && (r_count != '0);

  always_comb begin
    bus.flush_busy = 1'b1;
    bus.predict_en = 1'b0;
    bus.tbl_we     = 1'b0;
    bus.tbl_clr    = 1'b0;
    bus.tbl_idx    = '0;
    bus.tbl_pc     = '0;
    bus.tbl_target = '0;
    bus.tbl_taken  = 1'b0;
    bus.tbl_jump   = 1'b0;
    bus.tbl_call   = 1'b0;
    bus.tbl_ret    = 1'b0;
    if (r_state == ST_SWEEP) begin
      bus.tbl_we  = 1'b1;
      bus.tbl_clr = 1'b1;
      bus.tbl_idx = r_sweep_idx;
    end else begin
      bus.flush_busy = 1'b0;
      bus.predict_en = 1'b1;
      if (w_pop) begin
        bus.tbl_we     = 1'b1;
        bus.tbl_idx    = w_head.pc[IDX_W+1:2];
        bus.tbl_pc     = w_head.pc;
        bus.tbl_target = w_head.target;
        bus.tbl_taken  = w_head.taken;
        bus.tbl_jump   = w_head.jump;
        bus.tbl_call   = w_head.call;
        bus.tbl_ret    = w_head.ret;
      end else if (w_bypass) begin
        bus.tbl_we     = 1'b1;
        bus.tbl_idx    = w_in.pc[IDX_W+1:2];
        bus.tbl_pc     = w_in.pc;
        bus.tbl_target = w_in.target;
        bus.tbl_taken  = w_in.taken;
        bus.tbl_jump   = w_in.jump;
        bus.tbl_call   = w_in.call;
        bus.tbl_ret    = w_in.ret;
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else if (bus.flush_req) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_SWEEP: begin
          if (r_sweep_idx == C_LAST_IDX) begin
            r_state     <= ST_RUN;
            r_sweep_idx <= '0;
          end else begin
            r_sweep_idx <= r_sweep_idx + IDX_W'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_maint_ctrl.sv
// ============================================================================
// Module   : tb_bp_maint_ctrl
// Purpose  : Randomized scoreboard bench for bp_maint_ctrl against a
//            queue-based reference model of the write-port schedule.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_maint_ctrl;

  localparam int WIDTH   = 32;
  localparam int ENTRIES = 32;
  localparam int QDEPTH  = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic [3:0]  fl;
  } upd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bp_maint_if #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) bus ();

  bp_maint_ctrl #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .QDEPTH(QDEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  upd_t exp_q[$];
  bit   m_sweep = 1'b1;
  int   m_sidx  = 0;
  bit   m_ready = 1'b1;
  bit   m_byp   = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model + monitor: the model state describes the cycle now visible.
  always @(negedge clk) begin
    bit   exp_we;
    bit   exp_clr;
    bit   normal;
    bit   popped;
    int   exp_idx;
    upd_t w;
    if (rst) begin
      m_sweep = 1'b1;
      m_sidx  = 0;
      exp_q.delete();
    end
    exp_we  = 1'b0;
    exp_clr = 1'b0;
    normal  = 1'b0;
    popped  = 1'b0;
    exp_idx = 0;
    m_byp   = 1'b0;
    if (m_sweep) begin
      exp_we  = 1'b1;
      exp_clr = 1'b1;
      exp_idx = m_sidx;
    end else if (exp_q.size() > 0) begin
      exp_we = 1'b1;
      w      = exp_q[0];
      normal = 1'b1;
      popped = 1'b1;
    end
`ifdef BP_UPD_BYPASS_EN
    else if (bus.upd_valid && !bus.flush_req && !rst) begin
      exp_we   = 1'b1;
      w.pc     = bus.upd_pc;
      w.target = bus.upd_target;
      w.fl     = {bus.upd_taken, bus.upd_jump, bus.upd_call, bus.upd_ret};
      normal   = 1'b1;
      m_byp    = 1'b1;
    end
`endif
    if (normal) begin
      exp_idx = int'((w.pc >> 2) % ENTRIES);
    end
    m_ready = (exp_q.size() != QDEPTH);
    chk("upd_ready", 64'(bus.upd_ready), 64'(m_ready));
    chk("tbl_we", 64'(bus.tbl_we), 64'(exp_we));
    chk("flush_busy", 64'(bus.flush_busy), 64'(m_sweep));
    chk("predict_en", 64'(bus.predict_en), 64'(!m_sweep));
    if (exp_we) begin
      chk("tbl_clr", 64'(bus.tbl_clr), 64'(exp_clr));
      chk("tbl_idx", 64'(bus.tbl_idx), 64'(exp_idx));
    end
    if (normal) begin
      chk("tbl_pc", 64'(bus.tbl_pc), 64'(w.pc));
      chk("tbl_target", 64'(bus.tbl_target), 64'(w.target));
      chk("tbl_flags", 64'({bus.tbl_taken, bus.tbl_jump, bus.tbl_call, bus.tbl_ret}),
          64'(w.fl));
    end
    if (popped) begin
      void'(exp_q.pop_front());
    end
    if (bus.flush_req && !rst) begin
      m_sweep = 1'b1;
      m_sidx  = 0;
      exp_q.delete();
    end else if (!rst && m_sweep) begin
      if (m_sidx == ENTRIES - 1) begin
        m_sweep = 1'b0;
        m_sidx  = 0;
      end else begin
        m_sidx++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [3:0] fl);
    int   waited;
    upd_t u;
    waited         = 0;
    u.pc           = pc;
    u.target       = tgt;
    u.fl           = fl;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    {bus.upd_taken, bus.upd_jump, bus.upd_call, bus.upd_ret} = fl;
    forever begin
      @(posedge clk);
      if (m_ready) begin
        if (!m_byp) exp_q.push_back(u);
        break;
      end
      waited++;
      if (waited > 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: got no accept, expected accept within 100 cycles");
        break;
      end
    end
    #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic send_rand();
    send_upd($urandom, $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic flush_pulse(input bit with_upd);
    bus.flush_req = 1'b1;
    if (with_upd) begin
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = $urandom;
      bus.upd_target = $urandom;
    end
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    bus.upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_jump   = 1'b0;
    bus.upd_call   = 1'b0;
    bus.upd_ret    = 1'b0;
    bus.flush_req  = 1'b0;

    // Reset sweep, with six back-to-back updates offered during it.
    idle(3);
    rst = 1'b0;
    idle(5);
    repeat (6) send_rand();
    idle(10);

    // Single update: pc 0x104 maps to entry 1.
    send_upd(32'h0000_0104, 32'h0000_0200, 4'b1000);
    idle(3);

    // Flush discards queue: start a sweep, queue 3, flush alongside a 4th.
    flush_pulse(1'b0);
    idle(2);
    repeat (3) send_rand();
    flush_pulse(1'b1);
    idle(40);
    chk("discard_empty", 64'(exp_q.size()), 64'd0);

    // Flush while the sweep is at entry 17.
    flush_pulse(1'b0);
    idle(17);
    chk("sweep_at_17", 64'(bus.tbl_idx), 64'd17);
    flush_pulse(1'b0);
    idle(40);

    // Wrap-around: 10 updates with random pauses.
    for (int i = 0; i < 10; i++) begin
      send_rand();
      idle($urandom_range(0, 3));
    end
    idle(8);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0) flush_pulse($urandom_range(0, 1) == 1);
      send_rand();
      idle($urandom_range(0, 2));
    end
    idle(40);

    // Asynchronous reset mid-operation.
    flush_pulse(1'b0);
    idle(3);
    repeat (3) send_rand();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(40);
    for (int i = 0; i < 12; i++) send_rand();
    idle(10);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
